// File: rtl/gift64_key_schedule_if.sv
// Handshake bundle between the GIFT-64 key-schedule and its host: master key
// load on one side, round-key stream to the round datapath on the other.
interface gift64_key_schedule_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         key_dir;
  logic         rk_valid;
  logic         rk_ready;
  logic [63:0]  rk_mask;
  logic [5:0]   rk_index;
  logic         rk_last;
  logic         done;

  modport master (
    output key_in, key_valid, key_dir, rk_ready,
    input  key_ready, rk_valid, rk_mask, rk_index, rk_last, done
  );

  modport slave (
    input  key_in, key_valid, key_dir, rk_ready,
    output key_ready, rk_valid, rk_mask, rk_index, rk_last, done
  );
endinterface

// File: rtl/gift64_key_schedule.sv
// Iterative GIFT-64 round-key generator: one 64-bit XOR mask per accepted beat.
// Define GIFT64_KS_DECRYPT_EN to add reverse-order (decrypt) sequencing.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for a master key, key_ready high
//   S_FFWD | reverse mode only: running ROUNDS-1 forward steps to the last key
//   S_EMIT | streaming masks; first cycle is a load gap with rk_valid low
module gift64_key_schedule #(
  parameter int ROUNDS = 28
) (
  input logic              clk,
  input logic              rst,
  gift64_key_schedule_if.slave ks
);

  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

`ifdef GIFT64_KS_DECRYPT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EMIT = 2'd1, S_FFWD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EMIT = 2'd1} state_t;
`endif

  state_t       state_q;
  logic [127:0] key_q;
  logic [5:0]   c_q;
  logic [5:0]   idx_q;
  logic         valid_q;
  logic         done_q;
  logic         dir_q;
  logic [63:0]  mask_raw;
  logic         is_last;

`ifdef GIFT64_KS_DECRYPT_EN
  logic [5:0]   ffwd_cnt;
`else
  logic         unused_key_dir;
  assign unused_key_dir = ks.key_dir;
  assign dir_q = 1'b0;
`endif

  function automatic logic [127:0] fwd_key(input logic [127:0] k);
    return {k[17:16], k[31:18], k[11:0], k[15:12], k[127:32]};
  endfunction

  function automatic logic [5:0] fwd_c(input logic [5:0] c);
    return {c[4:0], c[5] ^ c[4] ^ 1'b1};
  endfunction

`ifdef GIFT64_KS_DECRYPT_EN
  function automatic logic [127:0] inv_key(input logic [127:0] k);
    return {k[95:0], k[125:112], k[127:126], k[99:96], k[111:100]};
  endfunction

  function automatic logic [5:0] inv_c(input logic [5:0] c);
    return {c[5] ^ c[0] ^ 1'b1, c[5:1]};
  endfunction
`endif

  // U = k1 lands on bit 4i+1, V = k0 on bit 4i, constant on bits 4j+3.
  always_comb begin
    mask_raw = '0;
    for (int i = 0; i < 16; i++) begin
      mask_raw[4*i+1] = key_q[16+i];
      mask_raw[4*i]   = key_q[i];
    end
    for (int j = 0; j < 6; j++) begin
      mask_raw[4*j+3] = c_q[j];
    end
    mask_raw[63] = 1'b1;
  end

  assign is_last = dir_q ? (idx_q == 6'd0) : (idx_q == LAST_IDX);

  assign ks.key_ready = (state_q == S_IDLE);
  assign ks.rk_valid  = valid_q;
  assign ks.rk_mask   = valid_q ? mask_raw : 64'd0;
  assign ks.rk_index  = idx_q;
  assign ks.rk_last   = valid_q && is_last;
  assign ks.done      = done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      key_q    <= '0;
      c_q      <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef GIFT64_KS_DECRYPT_EN
      dir_q    <= 1'b0;
      ffwd_cnt <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ks.key_valid) begin
            key_q   <= ks.key_in;
            c_q     <= 6'h01;
            valid_q <= 1'b0;
`ifdef GIFT64_KS_DECRYPT_EN
            dir_q   <= ks.key_dir;
            if (ks.key_dir) begin
              state_q  <= S_FFWD;
              ffwd_cnt <= LAST_IDX;
              idx_q    <= LAST_IDX;
            end else begin
              state_q <= S_EMIT;
              idx_q   <= 6'd0;
            end
`else
            state_q <= S_EMIT;
            idx_q   <= 6'd0;
`endif
          end
        end
`ifdef GIFT64_KS_DECRYPT_EN
        S_FFWD: begin
          key_q    <= fwd_key(key_q);
          c_q      <= fwd_c(c_q);
          ffwd_cnt <= ffwd_cnt - 6'd1;
          if (ffwd_cnt == 6'd1) begin
            state_q <= S_EMIT;
          end
        end
`endif
        S_EMIT: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (ks.rk_ready) begin
            if (is_last) begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
`ifdef GIFT64_KS_DECRYPT_EN
            end else if (dir_q) begin
              key_q <= inv_key(key_q);
              c_q   <= inv_c(c_q);
              idx_q <= idx_q - 6'd1;
`endif
            end else begin
              key_q <= fwd_key(key_q);
              c_q   <= fwd_c(c_q);
              idx_q <= idx_q + 6'd1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
